// File: rtl/uart_rx_addr.sv
// 8N1 UART receiver with 16x oversampling; presents each good byte with its
// 2-bit node-address field (bits 7:6) and flags framing errors.
module uart_rx_addr #(
    parameter int unsigned BAUD_DIV = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic [1:0] rx_id,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned PW = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned BW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [PW-1:0] PMAX     = PW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMID     = TW'(7);
    localparam logic [TW-1:0] TLAST    = TW'(15);
    localparam logic [BW-1:0] BLAST    = BW'(7);

    logic          sync1;
    logic          rxs;
    logic          rxs_d;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic [BW-1:0] bidx;
    logic [BW-1:0] bidx_nxt;
    logic [DW-1:0] shift;
    logic [DW-1:0] shift_nxt;
    logic [DW-1:0] data_nxt;
    logic [IW-1:0] id_nxt;
    logic          valid_nxt;
    logic          ferr_nxt;
    logic          busy_nxt;
    logic          tick_c;

    // Two-flop synchronizer plus delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign tick_c = (state != IDLE) && (pcnt == PMAX);

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = tick_c ? '0 : pcnt + PW'(1);
        tcnt_nxt  = tcnt;
        bidx_nxt  = bidx;
        shift_nxt = shift;
        data_nxt  = rx_data;
        id_nxt    = rx_id;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                pcnt_nxt = '0;
                tcnt_nxt = '0;
                bidx_nxt = '0;
                if (rxs_d && !rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick_c) begin
                    if (tcnt == TMID) begin
                        tcnt_nxt  = '0;
                        bidx_nxt  = '0;
                        state_nxt = rxs ? IDLE : DATA;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    // tcnt wraps to 0 on the sampling tick
                    tcnt_nxt = tcnt + TW'(1);
                    if (tcnt == TLAST) begin
                        shift_nxt[bidx] = rxs;
                        if (bidx == BLAST) begin
                            state_nxt = STOP;
                        end else begin
                            bidx_nxt = bidx + BW'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    tcnt_nxt = tcnt + TW'(1);
                    if (tcnt == TLAST) begin
                        if (rxs) begin
                            data_nxt  = shift;
                            id_nxt    = shift[DW-1:DW-IW];
                            valid_nxt = 1'b1;
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            bidx      <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_id     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pcnt      <= pcnt_nxt;
            tcnt      <= tcnt_nxt;
            bidx      <= bidx_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_id     <= id_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_addr.sv
// Bench for uart_rx_addr: sample-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames/glitches.
module tb_uart_rx_addr;

    localparam int unsigned D   = 4;
    localparam int unsigned BIT = 16 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic [1:0] rx_id;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_addr #(.BAUD_DIV(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_id     (rx_id),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    longint tcyc = 0;
    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    // Reference model: line history seen through a 2-clk synchronizer, start
    // detected on a falling edge while idle, then bits sampled at the
    // prescribed tick offsets (tick t lands D*t clocks after detection).
    logic [2:0] q       = 3'b111;
    logic       m_busy  = 1'b0;
    logic [7:0] m_shift = 8'h00;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    longint     cyc     = 0;
    longint     n0      = 0;
    longint     d;
    longint     k;
    logic       m_rxs;
    logic       m_rxs_d;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q       = 3'b111;
            m_busy  = 1'b0;
            m_shift = 8'h00;
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            cyc     = 0;
        end else begin
            cyc++;
            m_rxs   = q[1];
            m_rxs_d = q[2];
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            if (!m_busy) begin
                if (m_rxs_d && !m_rxs) begin
                    m_busy = 1'b1;
                    n0     = cyc;
                end
            end else begin
                d = cyc - n0;
                if (d == 8 * D) begin
                    if (m_rxs) m_busy = 1'b0;
                end else if (d > 8 * D && ((d - 8 * D) % BIT) == 0) begin
                    k = (d - 8 * D) / BIT - 1;
                    if (k < 8) begin
                        m_shift[k] = m_rxs;
                    end else begin
                        if (m_rxs) begin
                            m_data  = m_shift;
                            m_valid = 1'b1;
                        end else begin
                            m_ferr = 1'b1;
                        end
                        m_busy = 1'b0;
                    end
                end
            end
            q = {q[1:0], rx_serial};
        end
    end

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    longint     valid_cyc = 0;
    longint     start_cyc = 0;
    logic [1:0] id_q[$];

    // Compare DUT against the model on every falling clock edge.
    initial forever begin
        @(negedge clk);
        chk("rx_valid", 32'(rx_valid), 32'(m_valid));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_id", 32'(rx_id), 32'(m_data[7:6]));
        chk("valid_ferr_excl", 32'(rx_valid & frame_err), 32'(0));
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = tcyc;
            id_q.push_back(rx_id);
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drive one frame; cut>0 aborts after that many clocks.
    task automatic frame(input logic [7:0] b, input logic stop, input int cut);
        logic [9:0] bits;
        int n;
        bits = {stop, b, 1'b0};
        n = 0;
        start_cyc = tcyc;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < int'(BIT); j++) begin
                if (cut > 0 && n == cut) return;
                rx_serial = bits[i];
                n++;
                @(posedge clk);
                #2;
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        int r;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", 32'(rx_data), 32'h00);
        chk("reset_id", 32'(rx_id), 32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        idle(10);

        // Good frame
        frame(8'hC5, 1'b1, 0);
        idle(100);
        chk("c5_latency", 32'(valid_cyc - start_cyc), 32'd611);
        chk("c5_data", 32'(rx_data), 32'hC5);
        chk("c5_id", 32'(rx_id), 32'h3);
        chk("c5_vcnt", 32'(valid_cnt), 32'd1);
        chk("c5_fcnt", 32'(ferr_cnt), 32'd0);
        chk("c5_busy", 32'(busy), 32'h0);

        // Framing error keeps previous byte
        frame(8'h3A, 1'b0, 0);
        idle(100);
        chk("fe_fcnt", 32'(ferr_cnt), 32'd1);
        chk("fe_vcnt", 32'(valid_cnt), 32'd1);
        chk("fe_data", 32'(rx_data), 32'hC5);
        chk("fe_id", 32'(rx_id), 32'h3);

        // Short glitch rejected
        rx_serial = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        idle(200);
        chk("gl_busy", 32'(busy), 32'h0);
        chk("gl_vcnt", 32'(valid_cnt), 32'd1);
        chk("gl_fcnt", 32'(ferr_cnt), 32'd1);
        frame(8'h41, 1'b1, 0);
        idle(100);
        chk("41_data", 32'(rx_data), 32'h41);
        chk("41_id", 32'(rx_id), 32'h1);
        chk("41_vcnt", 32'(valid_cnt), 32'd2);

        // Back-to-back frames
        id_q.delete();
        frame(8'h80, 1'b1, 0);
        frame(8'h00, 1'b1, 0);
        frame(8'hFF, 1'b1, 0);
        idle(100);
        chk("b2b_count", 32'(id_q.size()), 32'd3);
        if (id_q.size() == 3) begin
            chk("b2b_id0", 32'(id_q[0]), 32'h2);
            chk("b2b_id1", 32'(id_q[1]), 32'h0);
            chk("b2b_id2", 32'(id_q[2]), 32'h3);
        end
        chk("b2b_vcnt", 32'(valid_cnt), 32'd5);

        // Reset during data bit 4
        frame(8'hAA, 1'b1, int'(BIT) * 5 + int'(BIT) / 2);
        chk("mid_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_data", 32'(rx_data), 32'h00);
        chk("mid_id", 32'(rx_id), 32'h0);
        chk("mid_valid", 32'(rx_valid), 32'h0);
        chk("mid_ferr", 32'(frame_err), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        rx_serial = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        idle(20);
        frame(8'h7E, 1'b1, 0);
        idle(100);
        chk("7e_data", 32'(rx_data), 32'h7E);
        chk("7e_id", 32'(rx_id), 32'h1);
        chk("7e_vcnt", 32'(valid_cnt), 32'd6);

        // Stuck-low line after a framing error
        frame(8'h99, 1'b0, 0);
        rx_serial = 1'b0;
        repeat (30 * BIT) @(posedge clk);
        #2;
        chk("stuck_busy", 32'(busy), 32'h0);
        chk("stuck_fcnt", 32'(ferr_cnt), 32'd2);
        chk("stuck_vcnt", 32'(valid_cnt), 32'd6);
        idle(100);
        frame(8'h55, 1'b1, 0);
        idle(100);
        chk("55_data", 32'(rx_data), 32'h55);
        chk("55_id", 32'(rx_id), 32'h1);
        chk("55_vcnt", 32'(valid_cnt), 32'd7);

        // Randomized frames, stop bits, gaps and glitches
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rx_serial = 1'b0;
                repeat ($urandom_range(1, 60)) @(posedge clk);
                #2;
                idle(700);
            end else begin
                rb = 8'($urandom);
                frame(rb, ($urandom_range(0, 7) != 0), 0);
                idle(int'($urandom_range(0, 80)));
            end
        end
        idle(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
